// File: rtl/wb_master_bridge.sv
// rtl/wb_master_bridge.sv - CPU valid/ready to Wishbone classic single-transfer bridge; optional retry via `WB_RETRY_EN
module wb_master_bridge #(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 512,
  parameter int ALIGN_CHECK    = 1,
  parameter int MAX_RETRIES    = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_we,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [DATA_W-1:0]   req_wdata,
  input  logic [DATA_W/8-1:0] req_be,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic                rsp_err,
  output logic                wb_cyc,
  output logic                wb_stb,
  output logic                wb_we,
  output logic [ADDR_W-1:0]   wb_adr,
  output logic [DATA_W/8-1:0] wb_sel,
  output logic [DATA_W-1:0]   wb_dat_mosi,
  input  logic [DATA_W-1:0]   wb_dat_miso,
  input  logic                wb_ack,
  input  logic                wb_err,
  output logic                timeout_pulse,
  output logic [15:0]         err_count
);

  localparam int BE_W = DATA_W / 8;
  localparam int WD_W = $clog2(TIMEOUT_CYCLES);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BUS   = 2'd1,
    ST_RESP  = 2'd2
`ifdef WB_RETRY_EN
    , ST_RETRY = 2'd3
`endif
  } state_t;

  state_t            state_q, state_d;
  logic              req_ready_q, req_ready_d;
  logic              cyc_q, cyc_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] adr_q, adr_d;
  logic [BE_W-1:0]   sel_q, sel_d;
  logic [DATA_W-1:0] dat_q, dat_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
  logic              rsp_err_q, rsp_err_d;
  logic              tpulse_q, tpulse_d;
  logic [15:0]       err_cnt_q, err_cnt_d;
  logic [WD_W-1:0]   wdog_q, wdog_d;
  logic              err_inc;
  logic              misaligned;

`ifdef WB_RETRY_EN
  localparam int RC_W = (MAX_RETRIES < 1) ? 1 : $clog2(MAX_RETRIES + 1);
  logic [RC_W-1:0] retry_cnt_q, retry_cnt_d;
`endif

  assign misaligned = (ALIGN_CHECK != 0) && (req_addr[1:0] != 2'b00);

  // Next-state and next-output computation for the single-outstanding bridge
  always_comb begin
    state_d     = state_q;
    req_ready_d = req_ready_q;
    cyc_d       = cyc_q;
    we_d        = we_q;
    adr_d       = adr_q;
    sel_d       = sel_q;
    dat_d       = dat_q;
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    tpulse_d    = 1'b0;
    wdog_d      = wdog_q;
    err_inc     = 1'b0;
`ifdef WB_RETRY_EN
    retry_cnt_d = retry_cnt_q;
`endif
    case (state_q)
      ST_IDLE: begin
        req_ready_d = 1'b1;
        if (req_valid && req_ready_q) begin
          we_d        = req_we;
          adr_d       = req_addr;
          sel_d       = req_be;
          dat_d       = req_wdata;
          req_ready_d = 1'b0;
          wdog_d      = '0;
`ifdef WB_RETRY_EN
          retry_cnt_d = '0;
`endif
          if (misaligned) begin
            // Rejected locally: the bus never sees this request
            state_d     = ST_RESP;
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
            rsp_rdata_d = '0;
            err_inc     = 1'b1;
          end else begin
            state_d = ST_BUS;
            cyc_d   = 1'b1;
          end
        end
      end
      ST_BUS: begin
        wdog_d = wdog_q + 1'b1;
        if (cyc_q && wb_err) begin
          // err wins over a simultaneous ack
          cyc_d = 1'b0;
`ifdef WB_RETRY_EN
          if (retry_cnt_q < RC_W'(MAX_RETRIES)) begin
            state_d = ST_RETRY;
          end else
`endif
          begin
            state_d     = ST_RESP;
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
            rsp_rdata_d = '0;
            err_inc     = 1'b1;
          end
        end else if (cyc_q && wb_ack) begin
          cyc_d       = 1'b0;
          state_d     = ST_RESP;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b0;
          rsp_rdata_d = we_q ? '0 : wb_dat_miso;
        end else if (wdog_q == WD_LAST) begin
          // Local watchdog abort; never retried
          cyc_d       = 1'b0;
          tpulse_d    = 1'b1;
          state_d     = ST_RESP;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b1;
          rsp_rdata_d = '0;
          err_inc     = 1'b1;
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          state_d     = ST_IDLE;
          rsp_valid_d = 1'b0;
          rsp_rdata_d = '0;
          rsp_err_d   = 1'b0;
          req_ready_d = 1'b1;
        end
      end
`ifdef WB_RETRY_EN
      ST_RETRY: begin
        // One idle bus cycle, then reissue the same latched transfer
        retry_cnt_d = retry_cnt_q + 1'b1;
        wdog_d      = '0;
        cyc_d       = 1'b1;
        state_d     = ST_BUS;
      end
`endif
      default: begin
        state_d     = ST_IDLE;
        cyc_d       = 1'b0;
        rsp_valid_d = 1'b0;
        req_ready_d = 1'b0;
      end
    endcase
    err_cnt_d = (err_inc && (err_cnt_q != 16'hFFFF)) ? err_cnt_q + 16'd1 : err_cnt_q;
  end

  // State and registered outputs, synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      req_ready_q <= 1'b0;
      cyc_q       <= 1'b0;
      we_q        <= 1'b0;
      adr_q       <= '0;
      sel_q       <= '0;
      dat_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
      tpulse_q    <= 1'b0;
      err_cnt_q   <= '0;
      wdog_q      <= '0;
`ifdef WB_RETRY_EN
      retry_cnt_q <= '0;
`endif
    end else begin
      state_q     <= state_d;
      req_ready_q <= req_ready_d;
      cyc_q       <= cyc_d;
      we_q        <= we_d;
      adr_q       <= adr_d;
      sel_q       <= sel_d;
      dat_q       <= dat_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
      tpulse_q    <= tpulse_d;
      err_cnt_q   <= err_cnt_d;
      wdog_q      <= wdog_d;
`ifdef WB_RETRY_EN
      retry_cnt_q <= retry_cnt_d;
`endif
    end
  end

  assign req_ready     = req_ready_q;
  assign rsp_valid     = rsp_valid_q;
  assign rsp_rdata     = rsp_rdata_q;
  assign rsp_err       = rsp_err_q;
  assign wb_cyc        = cyc_q;
  assign wb_stb        = cyc_q;
  assign wb_we         = cyc_q & we_q;
  assign wb_adr        = cyc_q ? adr_q : '0;
  assign wb_sel        = cyc_q ? sel_q : '0;
  assign wb_dat_mosi   = cyc_q ? dat_q : '0;
  assign timeout_pulse = tpulse_q;
  assign err_count     = err_cnt_q;

endmodule

// File: doc/wb_master_bridge.md
Name: wb_master_bridge

Overview:
- Converts the CPU core's valid/ready load/store requests into single Wishbone classic cycles.
- Sits directly upstream of the Wishbone interconnect and drives its master-side port.
- Allows one outstanding transaction at a time.
- Returns read data, or an error response, to the core. Errors come from slave err, interconnect decode/timeout err, a local watchdog, or misalignment.

Parameters:
- ADDR_W, 32, address width on both sides.
- DATA_W, 32, data width; byte-enable width is DATA_W/8.
- TIMEOUT_CYCLES, 512, local watchdog limit in cycles for the BUS state; must be greater than 256 so the interconnect's own timeout fires first.
- ALIGN_CHECK, 1, 1 = reject addresses with addr[1:0] != 0 without starting a bus cycle.
- MAX_RETRIES, 2, retry attempts per request (used only with WB_RETRY_EN).

Ports:
- clk  input  1  system clock, all logic on rising edge
- rst  input  1  reset, synchronous, active-low (0 = reset), sampled on rising clk
- req_valid  input  1  core request valid
- req_ready  output  1  bridge can accept a request
- req_we  input  1  1 = write, 0 = read
- req_addr  input  ADDR_W  byte address
- req_wdata  input  DATA_W  write data
- req_be  input  DATA_W/8  byte enables
- rsp_valid  output  1  response valid
- rsp_ready  input  1  core accepts the response
- rsp_rdata  output  DATA_W  read data (0 for writes and errors)
- rsp_err  output  1  response is an error
- wb_cyc, wb_stb, wb_we  output  1 each  Wishbone master controls
- wb_adr  output  ADDR_W
- wb_sel  output  DATA_W/8
- wb_dat_mosi  output  DATA_W
- wb_dat_miso  input  DATA_W
- wb_ack, wb_err  input  1 each
- timeout_pulse  output  1  one-cycle pulse on a watchdog abort
- err_count  output  16  saturating count of error responses

Behaviour:
- Reset (rst=0):
  - State goes to IDLE.
  - All outputs are 0, except req_ready, which is 1 from the first cycle after reset releases.
  - err_count is cleared.
  - If reset hits mid-BUS, wb_cyc/wb_stb drop on that edge. A late ack/err arriving afterwards is ignored, and no response is generated.
- FSM states: IDLE, BUS, RESP (plus RETRY when the optional feature is enabled).
- IDLE:
  - req_ready=1.
  - On req_valid && req_ready, latch we/addr/wdata/be.
  - If ALIGN_CHECK && addr[1:0] != 0: go to RESP with rsp_err=1 and rsp_rdata=0; no bus cycle is issued.
  - Otherwise go to BUS.
- BUS:
  - wb_cyc=wb_stb=1 starting the cycle after acceptance.
  - adr/sel/we/dat_mosi come from the latched values and stay stable for the whole cycle.
  - req_ready=0.
  - Watchdog counts from 0.
  - On wb_ack: capture wb_dat_miso for reads (0 for writes), rsp_err=0, drop cyc/stb on the same edge, go to RESP.
  - On wb_err, or wb_ack && wb_err together: err wins; rsp_err=1, rdata=0, go to RESP.
  - Watchdog reaching TIMEOUT_CYCLES-1 with no ack/err: abort (cyc/stb drop), timeout_pulse=1 for one cycle, rsp_err=1, go to RESP.
  - ack/err is ignored whenever wb_cyc=0.
- RESP:
  - rsp_valid=1; rsp_rdata/rsp_err are held stable until rsp_ready.
  - On rsp_valid && rsp_ready, go to IDLE. req_ready returns to 1 the next cycle, so there is no same-cycle back-to-back acceptance.
- Latency:
  - Request accepted at cycle 0.
  - wb_cyc rises in cycle 1.
  - A zero-wait slave ack in cycle 1 gives rsp_valid in cycle 2.
- err_count increments by 1 on each error response entering RESP and saturates at 16'hFFFF.

Optional Feature:
- Macro: WB_RETRY_EN.
- Defined:
  - A wb_err in BUS with retry_cnt < MAX_RETRIES goes to RETRY instead of RESP.
  - RETRY holds cyc/stb=0 for exactly one cycle, increments retry_cnt, clears the watchdog, and reissues to BUS with identical latched values.
  - A response is produced only after final success, or after the error that follows MAX_RETRIES retries.
  - Watchdog aborts and misalignment errors are never retried.
  - err_count counts only the final error responses.
- Undefined: no RETRY state; every wb_err goes directly to RESP.

Test Plan:
- Read addr 0x0000_0010, slave acks in cycle 1 with 0xDEADBEEF -> wb_cyc high exactly 1 cycle; rsp_valid in cycle 2, rsp_rdata=0xDEADBEEF, rsp_err=0.
- Write addr 0x0000_0104, wdata 0x12345678, be 4'b0011, ack after 3 wait cycles -> wb_adr/wb_dat_mosi/wb_sel stable for 4 cycles; rsp_err=0, rsp_rdata=0.
- Read addr 0x0000_0013 with ALIGN_CHECK=1 -> wb_cyc never rises; rsp_err=1; err_count=1.
- Slave never responds, wb_err tied 0 -> abort after 512 BUS cycles; timeout_pulse high 1 cycle; rsp_err=1.
- ack and err asserted in the same cycle -> rsp_err=1, rsp_rdata=0. With WB_RETRY_EN: err twice then ack -> two 1-cycle cyc gaps, final rsp_err=0, err_count unchanged.
- rst=0 in BUS cycle 2, then ack asserted after release -> cyc drops on the reset edge, no rsp_valid, req_ready=1.
